// File: rtl/special_case_pkg.sv
// Shared definitions for the FP special-case pipeline.
//   op_e      : operation codes on in_op (OP_RSV behaves as OP_ADD)
//   cls_t     : per-operand classification registered in stage 1
//   qnan_bit  : bit idx of the canonical quiet NaN {0, all-ones exp, 1, zeros}
package special_case_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_RSV = 2'd3
  } op_e;

  typedef struct packed {
    logic nan;
    logic snan;
    logic inf;
    logic zero;
    logic sign;
  } cls_t;

  // Set for the quiet bit (man MSB) and every exponent bit; sign and the
  // remaining mantissa bits are zero.
  function automatic logic qnan_bit(input int unsigned idx,
                                    input int unsigned exp_w,
                                    input int unsigned man_w);
    return ((idx + 1) >= man_w) && (idx < (man_w + exp_w));
  endfunction

endpackage

// File: rtl/fp_classifier.sv
// Combinational classifier for one raw {sign,exp,man} operand.
//   op   : operand word
//   nan  : NaN (exp all-ones, man != 0); snan when man MSB is 0
//   inf  : infinity (exp all-ones, man == 0)
//   zero : exact zero, or subnormal when FLUSH_SUB is set
//   sign : operand sign bit
module fp_classifier #(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAN_W     = 23,
  parameter bit          FLUSH_SUB = 1'b1
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 nan,
  output logic                 snan,
  output logic                 inf,
  output logic                 zero,
  output logic                 sign
);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;
  logic             exp_ones;
  logic             exp_zero;
  logic             man_zero;

  assign sign     = op[EXP_W+MAN_W];
  assign exp_f    = op[EXP_W+MAN_W-1 -: EXP_W];
  assign man_f    = op[MAN_W-1:0];
  assign exp_ones = &exp_f;
  assign exp_zero = ~|exp_f;
  assign man_zero = ~|man_f;

  assign inf  = exp_ones & man_zero;
  assign nan  = exp_ones & ~man_zero;
  assign snan = nan & ~man_f[MAN_W-1];
  assign zero = exp_zero & (man_zero | FLUSH_SUB);

endmodule

// File: rtl/special_case_pipe.sv
// Two-stage FP special-case analyser with valid/ready flow control.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input handshake; in_op, op_1, op_2 are the payload
//   out_valid/out_ready : output handshake
//   legal               : no special case, datapath result is used
//   nan_res/inf_res/zero_res, res_sig : special-result class and sign
//   invalid             : IEEE invalid flag
//   res_word            : canonical special result (zero when legal)
// Stage 1 holds operand classes, stage 2 holds the registered decision.
module special_case_pipe
  import special_case_pkg::*;
#(
  parameter int unsigned EXP_W     = 8,
  parameter int unsigned MAN_W     = 23,
  parameter bit          FLUSH_SUB = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [EXP_W+MAN_W:0] op_1,
  input  logic [EXP_W+MAN_W:0] op_2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 legal,
  output logic                 nan_res,
  output logic                 inf_res,
  output logic                 zero_res,
  output logic                 res_sig,
  output logic                 invalid,
  output logic [EXP_W+MAN_W:0] res_word
);

  localparam int unsigned W = 1 + EXP_W + MAN_W;

  cls_t   c1, c2;
  logic   s1_v;
  op_e    s1_op;
  cls_t   s1_a, s1_b;
  logic   s2_v;
  logic   s1_load, s2_load;

  logic   is_sub, is_mul, s2e;
  logic   sgn_inf, sgn_zero;
  logic   d_nan, d_inf, d_zero, d_legal, d_sig, d_invalid;
  logic [W-1:0] d_word, qnan_w;

  fp_classifier #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FLUSH_SUB(FLUSH_SUB)) u_cls_1 (
    .op(op_1), .nan(c1.nan), .snan(c1.snan), .inf(c1.inf), .zero(c1.zero), .sign(c1.sign)
  );

  fp_classifier #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FLUSH_SUB(FLUSH_SUB)) u_cls_2 (
    .op(op_2), .nan(c2.nan), .snan(c2.snan), .inf(c2.inf), .zero(c2.zero), .sign(c2.sign)
  );

  // A stage may load when empty or when its contents leave this cycle.
  assign s2_load   = ~s2_v | out_ready;
  assign s1_load   = ~s1_v | s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_v;

  always_comb begin
    qnan_w = '0;
    for (int unsigned i = 0; i < W; i++) qnan_w[i] = qnan_bit(i, EXP_W, MAN_W);
  end

  always_comb begin
    is_sub   = (s1_op == OP_SUB);
    is_mul   = (s1_op == OP_MUL);
    s2e      = s1_b.sign ^ is_sub;
    d_nan    = 1'b0;
    d_inf    = 1'b0;
    d_zero   = 1'b0;
    sgn_inf  = 1'b0;
    sgn_zero = 1'b0;
    if (is_mul) begin
      d_nan    = s1_a.nan | s1_b.nan | (s1_a.inf & s1_b.zero) | (s1_a.zero & s1_b.inf);
      d_inf    = (s1_a.inf | s1_b.inf) & ~d_nan;
      d_zero   = (s1_a.zero | s1_b.zero) & ~d_nan & ~d_inf;
      sgn_inf  = s1_a.sign ^ s1_b.sign;
      sgn_zero = s1_a.sign ^ s1_b.sign;
    end else begin
      d_nan    = s1_a.nan | s1_b.nan | (s1_a.inf & s1_b.inf & (s1_a.sign != s2e));
      d_inf    = (s1_a.inf | s1_b.inf) & ~d_nan;
      d_zero   = s1_a.zero & s1_b.zero & ~d_nan & ~d_inf;
      sgn_inf  = s1_a.inf ? s1_a.sign : s2e;
      sgn_zero = s1_a.sign & s2e;
    end
    d_legal   = ~(d_nan | d_inf | d_zero);
    d_sig     = d_nan ? 1'b0 : d_inf ? sgn_inf : d_zero ? sgn_zero : 1'b0;
    d_invalid = s1_a.snan | s1_b.snan | (d_nan & ~s1_a.nan & ~s1_b.nan);
    d_word    = '0;
    if (d_nan)       d_word = qnan_w;
    else if (d_inf)  d_word = {d_sig, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (d_zero) d_word = {d_sig, {(W-1){1'b0}}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v     <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_v     <= 1'b0;
      legal    <= 1'b0;
      nan_res  <= 1'b0;
      inf_res  <= 1'b0;
      zero_res <= 1'b0;
      res_sig  <= 1'b0;
      invalid  <= 1'b0;
      res_word <= '0;
    end else begin
      if (s1_load) begin
        s1_v <= in_valid;
        if (in_valid) begin
          s1_op <= op_e'(in_op);
          s1_a  <= c1;
          s1_b  <= c2;
        end
      end
      if (s2_load) begin
        s2_v <= s1_v;
        if (s1_v) begin
          legal    <= d_legal;
          nan_res  <= d_nan;
          inf_res  <= d_inf;
          zero_res <= d_zero;
          res_sig  <= d_sig;
          invalid  <= d_invalid;
          res_word <= d_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_special_case_pipe.sv
// Directed self-checking bench for special_case_pipe (EXP_W=8, MAN_W=23).
// Two instances share stimulus: dut_a flushes subnormals, dut_b does not.
module tb_special_case_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_op;
  logic [31:0] op_1, op_2;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_legal, a_nan, a_inf, a_zero, a_sig, a_inv;
  logic [31:0] a_word;
  logic        b_in_ready, b_out_valid, b_legal, b_nan, b_inf, b_zero, b_sig, b_inv;
  logic [31:0] b_word;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  special_case_pipe #(.EXP_W(8), .MAN_W(23), .FLUSH_SUB(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_op(in_op),
    .op_1(op_1), .op_2(op_2), .out_valid(a_out_valid), .out_ready(out_ready),
    .legal(a_legal), .nan_res(a_nan), .inf_res(a_inf), .zero_res(a_zero),
    .res_sig(a_sig), .invalid(a_inv), .res_word(a_word)
  );

  special_case_pipe #(.EXP_W(8), .MAN_W(23), .FLUSH_SUB(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready), .in_op(in_op),
    .op_1(op_1), .op_2(op_2), .out_valid(b_out_valid), .out_ready(out_ready),
    .legal(b_legal), .nan_res(b_nan), .inf_res(b_inf), .zero_res(b_zero),
    .res_sig(b_sig), .invalid(b_inv), .res_word(b_word)
  );

  // flags are {legal, nan_res, inf_res, zero_res, res_sig, invalid}
  function automatic logic [5:0] flags_a();
    return {a_legal, a_nan, a_inf, a_zero, a_sig, a_inv};
  endfunction
  function automatic logic [5:0] flags_b();
    return {b_legal, b_nan, b_inf, b_zero, b_sig, b_inv};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated transaction with out_ready high; result appears two edges later.
  task automatic run_vec(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [5:0] fa, input logic [31:0] wa,
                         input logic [5:0] fb, input logic [31:0] wb);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_op     = op;
    op_1      = a;
    op_2      = b;
    @(negedge clk);
    in_valid  = 1'b0;
    check({tag, "_lat_a"}, {63'd0, a_out_valid}, 64'd0);
    @(negedge clk);
    check({tag, "_vld_a"}, {63'd0, a_out_valid}, 64'd1);
    check({tag, "_flg_a"}, {58'd0, flags_a()}, {58'd0, fa});
    check({tag, "_wrd_a"}, {32'd0, a_word}, {32'd0, wa});
    check({tag, "_vld_b"}, {63'd0, b_out_valid}, 64'd1);
    check({tag, "_flg_b"}, {58'd0, flags_b()}, {58'd0, fb});
    check({tag, "_wrd_b"}, {32'd0, b_word}, {32'd0, wb});
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_op    = op;
    op_1     = a;
    op_2     = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ovld", {63'd0, a_out_valid}, 64'd0);
    check("rst_flags", {58'd0, flags_a()}, 64'd0);
    check("rst_word", {32'd0, a_word}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_irdy", {63'd0, a_in_ready}, 64'd1);

    //       tag      op    op_1          op_2          flags_a    word_a        flags_b    word_b
    run_vec("inf_add", 2'd0, 32'h7F800000, 32'hFF800000, 6'b010001, 32'h7FC00000, 6'b010001, 32'h7FC00000);
    run_vec("zmulinf", 2'd2, 32'h00000000, 32'hFF800000, 6'b010001, 32'h7FC00000, 6'b010001, 32'h7FC00000);
    run_vec("mul_inf", 2'd2, 32'hC0000000, 32'h7F800000, 6'b001010, 32'hFF800000, 6'b001010, 32'hFF800000);
    run_vec("sub_z",   2'd1, 32'h80000000, 32'h00000000, 6'b000110, 32'h80000000, 6'b000110, 32'h80000000);
    run_vec("add_lgl", 2'd0, 32'h3F800000, 32'h40000000, 6'b100000, 32'h00000000, 6'b100000, 32'h00000000);
    run_vec("snan",    2'd0, 32'h7F800001, 32'h3F800000, 6'b010001, 32'h7FC00000, 6'b010001, 32'h7FC00000);
    run_vec("qnan",    2'd0, 32'h7FC00000, 32'h3F800000, 6'b010000, 32'h7FC00000, 6'b010000, 32'h7FC00000);
    run_vec("inf_pp",  2'd0, 32'h7F800000, 32'h7F800000, 6'b001000, 32'h7F800000, 6'b001000, 32'h7F800000);
    run_vec("sub_inf", 2'd1, 32'h7F800000, 32'h7F800000, 6'b010001, 32'h7FC00000, 6'b010001, 32'h7FC00000);
    run_vec("rsv_op",  2'd3, 32'h7F800000, 32'hFF800000, 6'b010001, 32'h7FC00000, 6'b010001, 32'h7FC00000);
    run_vec("add_z",   2'd0, 32'h80000000, 32'h00000000, 6'b000100, 32'h00000000, 6'b000100, 32'h00000000);
    run_vec("sub_add", 2'd0, 32'h00000001, 32'h3F800000, 6'b100000, 32'h00000000, 6'b100000, 32'h00000000);
    run_vec("sub_mul", 2'd2, 32'h00000001, 32'h7F800000, 6'b010001, 32'h7FC00000, 6'b001000, 32'h7F800000);

    // Back-pressure: A,B accepted, C stalls while out_ready is low for 3 cycles.
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h7F800000, 32'hFF800000);                 // A -> 7FC00000
    #1 check("bp_c0_irdy", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b1, 2'd2, 32'hC0000000, 32'h7F800000);                 // B -> FF800000
    #1 check("bp_c1_irdy", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b1, 2'd1, 32'h80000000, 32'h00000000);                 // C -> 80000000
    #1 check("bp_c2_irdy", {63'd0, a_in_ready}, 64'd0);
    check("bp_c2_word", {32'd0, a_word}, {32'd0, 32'h7FC00000});
    @(negedge clk);
    check("bp_c3_irdy", {63'd0, a_in_ready}, 64'd0);
    check("bp_c3_ovld", {63'd0, a_out_valid}, 64'd1);
    check("bp_c3_word", {32'd0, a_word}, {32'd0, 32'h7FC00000});
    out_ready = 1'b1;
    #1 check("bp_c3_irdy1", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    check("bp_outB", {32'd0, a_word}, {32'd0, 32'hFF800000});
    drive(1'b1, 2'd0, 32'h7F800000, 32'h3F800000);                 // D -> 7F800000
    #1 check("bp_c4_irdy", {63'd0, a_in_ready}, 64'd1);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("bp_outC", {32'd0, a_word}, {32'd0, 32'h80000000});
    check("bp_outC_vld", {63'd0, a_out_valid}, 64'd1);
    @(negedge clk);
    check("bp_outD", {32'd0, a_word}, {32'd0, 32'h7F800000});
    check("bp_outD_vld", {63'd0, a_out_valid}, 64'd1);
    @(negedge clk);
    check("bp_drain", {63'd0, a_out_valid}, 64'd0);

    // Reset with both stages full discards in-flight work.
    out_ready = 1'b0;
    drive(1'b1, 2'd0, 32'h7F800000, 32'h7F800000);
    @(negedge clk);
    drive(1'b1, 2'd2, 32'h00000000, 32'h7F800000);
    @(negedge clk);
    drive(1'b0, 2'd0, 32'h0, 32'h0);
    check("full_ovld", {63'd0, a_out_valid}, 64'd1);
    check("full_irdy", {63'd0, a_in_ready}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst2_ovld", {63'd0, a_out_valid}, 64'd0);
    check("rst2_irdy", {63'd0, a_in_ready}, 64'd1);
    check("rst2_word", {32'd0, a_word}, 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("stale_%0d", i), {62'd0, a_out_valid, b_out_valid}, 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
